// File: rtl/prepare_log_inserter.sv
// Packs an accepted PREPARE into log-memory lines: header first, then the payload
// realigned across line boundaries, one line written per cycle when both sides are ready.
module prepare_log_inserter #(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_DATA_BYTES = NOC_DATA_W / 8,
  parameter int LOG_HDR_W      = 128,
  parameter int LOG_HDR_BYTES  = LOG_HDR_W / 8,
  parameter int LEN_W          = 16,
  parameter int LOG_DEPTH_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_ins_start,
  input  logic [LOG_HDR_W-1:0]   datap_inserter_log_hdr,
  input  logic [LEN_W-1:0]       ctrl_ins_payload_len,
  input  logic                   manage_ins_data_val,
  input  logic [NOC_DATA_W-1:0]  manage_ins_data,
  output logic                   ins_manage_data_rdy,
  input  logic [LOG_DEPTH_W-1:0] prep_log_mem_wr_addr,
  output logic                   ins_log_mem_wr_val,
  output logic [LOG_DEPTH_W-1:0] ins_log_mem_wr_addr,
  output logic [NOC_DATA_W-1:0]  ins_log_mem_wr_data,
  input  logic                   log_mem_ins_wr_rdy,
  output logic                   log_ctrl_datap_incr_wr_addr,
  output logic                   ins_ctrl_done,
  output logic                   ins_ctrl_busy
);

  // state | meaning
  // IDLE  | waiting for ctrl_ins_start
  // FIRST | header line (plus first flit's top bytes when payload is non-empty)
  // MID   | carry bytes from previous flit followed by top bytes of the next flit
  // DRAIN | carry bytes of the last flit, zero-filled, no flit consumed
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_MID, S_DRAIN, S_DONE} state_t;

  localparam int TAIL_W = NOC_DATA_W - LOG_HDR_W;

  state_t                state_q, state_d;
  logic [LOG_HDR_W-1:0]  hdr_q, hdr_d;
  logic [LOG_HDR_W-1:0]  carry_q, carry_d;
  logic [LEN_W-1:0]      bytes_left_q, bytes_left_d;
  logic [LEN_W:0]        lines_left_q, lines_left_d;

  logic [NOC_DATA_W-1:0] flit_m;
  logic [LEN_W-1:0]      take;
  logic [LEN_W:0]        lines_calc;
  logic                  wr_val, data_rdy, consume, line_acc, done;
  logic [NOC_DATA_W-1:0] line;

  // Bytes past the end of the payload are forced to zero before realignment,
  // so the carry register never holds garbage either.
  always_comb begin
    flit_m = '0;
    for (int b = 0; b < NOC_DATA_BYTES; b++) begin
      if (LEN_W'(b) < bytes_left_q)
        flit_m[NOC_DATA_W-1-8*b -: 8] = manage_ins_data[NOC_DATA_W-1-8*b -: 8];
    end
  end

  assign take = (bytes_left_q > LEN_W'(NOC_DATA_BYTES)) ? LEN_W'(NOC_DATA_BYTES) : bytes_left_q;

  assign lines_calc = ({1'b0, ctrl_ins_payload_len}
                       + (LEN_W+1)'(LOG_HDR_BYTES + NOC_DATA_BYTES - 1))
                      / (LEN_W+1)'(NOC_DATA_BYTES);

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    carry_d      = carry_q;
    bytes_left_d = bytes_left_q;
    lines_left_d = lines_left_q;
    wr_val       = 1'b0;
    data_rdy     = 1'b0;
    consume      = 1'b0;
    done         = 1'b0;
    line         = '0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_ins_start) begin
          hdr_d        = datap_inserter_log_hdr;
          bytes_left_d = ctrl_ins_payload_len;
          lines_left_d = lines_calc;
          state_d      = S_FIRST;
        end
      end
      S_FIRST: begin
        if (bytes_left_q == '0) begin
          wr_val = 1'b1;
          line   = {hdr_q, {TAIL_W{1'b0}}};
        end else begin
          wr_val   = manage_ins_data_val;
          data_rdy = log_mem_ins_wr_rdy;
          consume  = 1'b1;
          line     = {hdr_q, flit_m[NOC_DATA_W-1 -: TAIL_W]};
        end
      end
      S_MID: begin
        wr_val   = manage_ins_data_val;
        data_rdy = log_mem_ins_wr_rdy;
        consume  = 1'b1;
        line     = {carry_q, flit_m[NOC_DATA_W-1 -: TAIL_W]};
      end
      S_DRAIN: begin
        wr_val = 1'b1;
        line   = {carry_q, {TAIL_W{1'b0}}};
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    line_acc = wr_val & log_mem_ins_wr_rdy;
    if (line_acc) begin
      lines_left_d = lines_left_q - 1'b1;
      if (consume) begin
        bytes_left_d = bytes_left_q - take;
        carry_d      = flit_m[LOG_HDR_W-1:0];
      end
      if (lines_left_d == '0)
        state_d = S_DONE;
      else if (bytes_left_d != '0)
        state_d = S_MID;
      else
        state_d = S_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hdr_q        <= '0;
      carry_q      <= '0;
      bytes_left_q <= '0;
      lines_left_q <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      carry_q      <= carry_d;
      bytes_left_q <= bytes_left_d;
      lines_left_q <= lines_left_d;
    end
  end

  // Outputs are held at zero while reset is asserted, not just after it takes effect.
  assign ins_log_mem_wr_val          = rst & wr_val;
  assign ins_manage_data_rdy         = rst & data_rdy;
  assign ins_log_mem_wr_data         = ins_log_mem_wr_val ? line : '0;
  assign ins_log_mem_wr_addr         = ins_log_mem_wr_val ? prep_log_mem_wr_addr : '0;
  assign log_ctrl_datap_incr_wr_addr = rst & line_acc;
  assign ins_ctrl_done               = rst & done;
  assign ins_ctrl_busy               = rst & (state_q != S_IDLE);

endmodule

// File: tb/tb_prepare_log_inserter.sv
// Scoreboard bench for prepare_log_inserter: expected lines are queued at stimulus time
// and a negedge monitor compares every accepted line write against them.
module tb_prepare_log_inserter;
  localparam int W  = 512;
  localparam int HW = 128;
  localparam int LW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ctrl_ins_start = 1'b0;
  logic [HW-1:0] datap_inserter_log_hdr = '0;
  logic [LW-1:0] ctrl_ins_payload_len = '0;
  logic          manage_ins_data_val = 1'b0;
  logic [W-1:0]  manage_ins_data = '0;
  logic          ins_manage_data_rdy;
  logic [AW-1:0] prep_log_mem_wr_addr;
  logic          ins_log_mem_wr_val;
  logic [AW-1:0] ins_log_mem_wr_addr;
  logic [W-1:0]  ins_log_mem_wr_data;
  logic          log_mem_ins_wr_rdy = 1'b0;
  logic          log_ctrl_datap_incr_wr_addr;
  logic          ins_ctrl_done;
  logic          ins_ctrl_busy;

  always #5 clk = ~clk;

  prepare_log_inserter dut (
    .clk                         (clk),
    .rst                         (rst),
    .ctrl_ins_start              (ctrl_ins_start),
    .datap_inserter_log_hdr      (datap_inserter_log_hdr),
    .ctrl_ins_payload_len        (ctrl_ins_payload_len),
    .manage_ins_data_val         (manage_ins_data_val),
    .manage_ins_data             (manage_ins_data),
    .ins_manage_data_rdy         (ins_manage_data_rdy),
    .prep_log_mem_wr_addr        (prep_log_mem_wr_addr),
    .ins_log_mem_wr_val          (ins_log_mem_wr_val),
    .ins_log_mem_wr_addr         (ins_log_mem_wr_addr),
    .ins_log_mem_wr_data         (ins_log_mem_wr_data),
    .log_mem_ins_wr_rdy          (log_mem_ins_wr_rdy),
    .log_ctrl_datap_incr_wr_addr (log_ctrl_datap_incr_wr_addr),
    .ins_ctrl_done               (ins_ctrl_done),
    .ins_ctrl_busy               (ins_ctrl_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int incr_cnt, flit_cnt, done_cnt, rdy_hi_cnt, done_cyc, start_cyc;
  bit stall_mode = 1'b0;
  logic [AW-1:0] dp_addr = AW'(37);

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [W-1:0]  flit_q[$];

  assign prep_log_mem_wr_addr = dp_addr;

  // Datapath model: address advances the cycle after each accepted line.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (log_ctrl_datap_incr_wr_addr) dp_addr <= dp_addr + 1'b1;
  end

  always @(posedge clk) begin
    #1;
    log_mem_ins_wr_rdy  = stall_mode ? (cyc % 2 == 0) : 1'b1;
    manage_ins_data_val = (flit_q.size() > 0) && (stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
    manage_ins_data     = (flit_q.size() > 0) ? flit_q[0] : '1;
  end

  always @(negedge clk) begin
    logic [W-1:0]  ed;
    logic [AW-1:0] ea;
    if (ins_log_mem_wr_val && log_mem_ins_wr_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_line actual addr=%0d required=no write", ins_log_mem_wr_addr);
      end else begin
        ed = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        if (ins_log_mem_wr_data !== ed || ins_log_mem_wr_addr !== ea) begin
          failures++;
          $display("FAIL line actual=%h@%0d required=%h@%0d", ins_log_mem_wr_data,
                   ins_log_mem_wr_addr, ed, ea);
        end
      end
    end
    if (manage_ins_data_val && ins_manage_data_rdy) begin
      flit_cnt++;
      if (flit_q.size() > 0) void'(flit_q.pop_front());
    end
    if (log_ctrl_datap_incr_wr_addr) incr_cnt++;
    if (ins_manage_data_rdy) rdy_hi_cnt++;
    if (ins_ctrl_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rnd_flit();
    logic [W-1:0] f;
    for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic push_line(input logic [W-1:0] d, input int idx);
    exp_q.push_back(d);
    exp_addr_q.push_back(dp_addr + AW'(idx));
  endtask

  task automatic start_entry(input int len, input logic [HW-1:0] hdr, input bit stall);
    incr_cnt = 0; flit_cnt = 0; done_cnt = 0; rdy_hi_cnt = 0; done_cyc = -1;
    stall_mode = stall;
    @(posedge clk); #2;
    ctrl_ins_start         = 1'b1;
    datap_inserter_log_hdr = hdr;
    ctrl_ins_payload_len   = LW'(len);
    start_cyc              = cyc;
    @(posedge clk); #2;
    ctrl_ins_start = 1'b0;
  endtask

  task automatic finish_entry(input string name, input int nlines, input int nflits);
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_incr"}, incr_cnt, nlines);
    chk({name, "_flits"}, flit_cnt, nflits);
    chk({name, "_lines_left"}, exp_q.size(), 0);
    chk({name, "_busy"}, int'(ins_ctrl_busy), 0);
    stall_mode = 1'b0;
  endtask

  task automatic setup_200(input logic [HW-1:0] h);
    logic [W-1:0] f[4];
    for (int i = 0; i < 4; i++) begin
      f[i] = rnd_flit();
      flit_q.push_back(f[i]);
    end
    push_line({h, f[0][511:128]}, 0);
    push_line({f[0][127:0], f[1][511:128]}, 1);
    push_line({f[1][127:0], f[2][511:128]}, 2);
    push_line({f[2][127:0], f[3][511:448], 320'b0}, 3);
  endtask

  initial begin
    logic [W-1:0]  f0, f1;
    logic [HW-1:0] h;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_val", int'(ins_log_mem_wr_val), 0);
    chk("rst_data_rdy", int'(ins_manage_data_rdy), 0);
    chk("rst_busy", int'(ins_ctrl_busy), 0);
    chk("rst_done", int'(ins_ctrl_done), 0);
    @(posedge clk); #2;
    rst = 1'b1;

    // zero payload
    h = {$urandom, $urandom, $urandom, $urandom};
    push_line({h, 384'b0}, 0);
    start_entry(0, h, 1'b0);
    finish_entry("zero", 1, 0);
    chk("zero_done_latency", done_cyc - start_cyc, 2);
    chk("zero_no_data_rdy", rdy_hi_cnt, 0);

    // exact fit
    h = {$urandom, $urandom, $urandom, $urandom};
    f0 = rnd_flit();
    flit_q.push_back(f0);
    push_line({h, f0[511:128]}, 0);
    start_entry(48, h, 1'b0);
    finish_entry("fit48", 1, 1);

    // one byte spills into a drain line
    h = {$urandom, $urandom, $urandom, $urandom};
    f0 = rnd_flit();
    flit_q.push_back(f0);
    push_line({h, f0[511:128]}, 0);
    push_line({f0[127:120], 504'b0}, 1);
    start_entry(49, h, 1'b0);
    finish_entry("spill49", 2, 1);

    // two flits, no drain
    h = {$urandom, $urandom, $urandom, $urandom};
    f0 = rnd_flit();
    f1 = rnd_flit();
    flit_q.push_back(f0);
    flit_q.push_back(f1);
    push_line({h, f0[511:128]}, 0);
    push_line({f0[127:0], f1[511:128]}, 1);
    start_entry(112, h, 1'b0);
    finish_entry("multi112", 2, 2);

    // 200 bytes, free-running then with backpressure
    h = {$urandom, $urandom, $urandom, $urandom};
    setup_200(h);
    start_entry(200, h, 1'b0);
    finish_entry("len200", 4, 4);

    h = {$urandom, $urandom, $urandom, $urandom};
    setup_200(h);
    start_entry(200, h, 1'b1);
    finish_entry("len200_stall", 4, 4);

    // reset after the first line of a 200-byte entry
    h = {$urandom, $urandom, $urandom, $urandom};
    setup_200(h);
    start_entry(200, h, 1'b0);
    for (int i = 0; i < 100 && incr_cnt < 1; i++) @(negedge clk);
    chk("mid_first_line", int'(incr_cnt >= 1), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wr_val", int'(ins_log_mem_wr_val), 0);
    chk("mid_rst_data_zero", int'(ins_log_mem_wr_data == '0), 1);
    chk("mid_rst_incr", int'(log_ctrl_datap_incr_wr_addr), 0);
    chk("mid_rst_data_rdy", int'(ins_manage_data_rdy), 0);
    chk("mid_rst_busy", int'(ins_ctrl_busy), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    flit_q.delete();
    repeat (2) @(posedge clk);
    #2;
    chk("mid_rst_idle", int'(ins_ctrl_busy), 0);
    chk("mid_rst_no_done", done_cnt, 0);

    h = {$urandom, $urandom, $urandom, $urandom};
    push_line({h, 384'b0}, 0);
    start_entry(0, h, 1'b0);
    finish_entry("post_rst_zero", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prepare_log_inserter.md
Name: prepare_log_inserter

Overview:
- Downstream of the prepare datapath/controller.
- Once a PREPARE is accepted (view/opnum OK, log has space), it takes the log header from the datapath and the request payload flits from the manage stage.
- It prepends the header and realigns the payload so the result is packed into log-memory lines.
- Each line is written at the address supplied by the datapath. The block pulses an increment per line and signals done when the entry is fully stored.

Parameters:
- NOC_DATA_W, 512, NoC flit width and log line width (bits).
- NOC_DATA_BYTES, NOC_DATA_W/8, bytes per flit/line.
- LOG_HDR_W, 128, log header width (bits); LOG_HDR_W < NOC_DATA_W, byte multiple.
- LOG_HDR_BYTES, LOG_HDR_W/8.
- LEN_W, 16, payload byte-length width.
- LOG_DEPTH_W, 10, log address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ctrl_ins_start  in  1  single-cycle start; header and length valid this cycle
- datap_inserter_log_hdr  in  LOG_HDR_W  log header to prepend
- ctrl_ins_payload_len  in  LEN_W  payload bytes after prepare header (may be 0)
- manage_ins_data_val  in  1  payload flit valid
- manage_ins_data  in  NOC_DATA_W  payload flit, MSB-first bytes
- ins_manage_data_rdy  out  1  payload flit accept
- prep_log_mem_wr_addr  in  LOG_DEPTH_W  current line address from datapath
- ins_log_mem_wr_val  out  1  line write valid
- ins_log_mem_wr_addr  out  LOG_DEPTH_W  line address (pass-through of prep_log_mem_wr_addr)
- ins_log_mem_wr_data  out  NOC_DATA_W  packed line
- log_mem_ins_wr_rdy  in  1  memory accepts write
- log_ctrl_datap_incr_wr_addr  out  1  pulse per accepted line write
- ins_ctrl_done  out  1  single-cycle pulse, entry fully written
- ins_ctrl_busy  out  1  high outside IDLE

Behaviour:
- Reset: rst is synchronous, active-low. All outputs are 0 on reset. State goes to IDLE, header/carry registers clear, counters clear.
- Start: on ctrl_ins_start in IDLE, register header and payload_len. Set bytes_left = payload_len, lines_left = ceil((payload_len + LOG_HDR_BYTES)/NOC_DATA_BYTES). Start while busy is ignored (controller error).
- States:
  - IDLE -> FIRST on start.
  - FIRST: if payload_len==0, drive line {hdr, zeros} with no flit consumed. Otherwise wait for a flit; line = {hdr, flit[NOC_DATA_W-1 -: NOC_DATA_W-LOG_HDR_W]}, and the carry register takes flit[LOG_HDR_W-1:0].
  - MID: line = {carry, flit[top NOC_DATA_W-LOG_HDR_W bits]}; carry updates from the low bits.
  - DRAIN: line = {carry, zeros}; no flit consumed.
  - DONE: ins_ctrl_done high one cycle -> IDLE.
- Transitions after each accepted line: lines_left-=1. If lines_left becomes 0 -> DONE. Else if bytes_left (flit bytes still to receive) > 0 -> MID, otherwise -> DRAIN.
- bytes_left decrements by min(NOC_DATA_BYTES, bytes_left) per consumed flit. At most ceil(payload_len/NOC_DATA_BYTES) flits are consumed; DRAIN occurs only when the last flit held more than NOC_DATA_BYTES-LOG_HDR_BYTES valid bytes.
- Handshake, FIRST (payload>0) and MID: ins_log_mem_wr_val = manage_ins_data_val; ins_manage_data_rdy = log_mem_ins_wr_rdy. The flit and the line transfer in the same cycle. No internal line buffer; combinational through, registered state only.
- Handshake, zero-payload FIRST and DRAIN: wr_val=1; data_rdy=0.
- log_ctrl_datap_incr_wr_addr = wr_val & wr_rdy; the datapath advances the address the following cycle.
- Bytes beyond payload_len in the final line are zero (mask using bytes_left); garbage past the end of the final flit is never written.
- Throughput: one line per cycle with continuous valid/rdy.
- Latency: start -> first write possible next cycle; last line accepted -> done next cycle.
- Reset mid-entry returns to IDLE with no done pulse; partial lines already written are not retracted (controller rewinds log_tail).

Test Plan (NOC_DATA_W=512, LOG_HDR_W=128):
- Zero payload: start, len=0, hdr=H -> one write {H,384'b0} at addr A, one incr pulse, no data_rdy, done 2 cycles after start.
- Exact fit: len=48, one flit F -> one write {H,F[511:128]}, F consumed same cycle, no DRAIN, done.
- Spill: len=49, one flit F -> writes {H,F[511:128]} then {F[127:120],120'b0...} (remaining bytes zero), 2 incr pulses, 1 flit consumed.
- Multi-flit: len=112, flits F0,F1 -> lines {H,F0[511:128]}, {F0[127:0],F1[511:128]}, done, exactly 2 flits consumed.
- Backpressure: len=200, toggle wr_rdy 0/1 every cycle and data_val randomly -> 4 lines identical to the no-stall case; no flit lost or duplicated; incr count=4.
- Reset mid-entry: assert rst (low) after line 1 of len=200 -> all outputs 0 next cycle, IDLE, no done; a new start with len=0 then behaves normally.
